fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined 8-bit CPU. Owns the program counter and drives the instruction-memory read address. Produces the IF/ID pipeline register consumed by the decode stage. Handles the reset-vector load from M[0], PC redirects from execute (JMP and taken branches), hazard stalls, and interrupt entry through the vector at M[1].

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/fetch_stage_int_pending.sv | 35 +++
 rtl/fetch_stage.sv | 172 +++++++++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU pipeline: fetch FSM states,
// default vector addresses, bubble encoding and IF/ID field widths.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;

  localparam logic [PC_W-1:0]    RST_VEC_ADDR = 8'h00;
  localparam logic [PC_W-1:0]    INT_VEC_ADDR = 8'h01;
  localparam logic [INSTR_W-1:0] NOP_INSTR    = 8'h00;

  typedef enum logic [1:0] {
    VEC_RST = 2'd0,
    RUN     = 2'd1,
    VEC_INT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus1;
    logic               valid;
  } ifid_t;

  // PC increment wraps silently at the top of the 8-bit space.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] value);
    return value + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_stage_int_pending.sv
// Interrupt request edge detector and pending flag for the fetch stage.
// Built only when FETCH_INT_EN is defined.
`ifdef FETCH_INT_EN
module int_pending (
  input  logic clk,
  input  logic rst,
  input  logic int_sig,
  input  logic clear,
  input  logic reset_abort,
  output logic pending
);

  logic int_prev;
  logic rise;

  assign rise = int_sig & ~int_prev;

  // A rise seen while already pending is absorbed, even on the clearing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      int_prev <= int_sig;
      if (reset_abort)
        pending <= 1'b1;
      else if (pending)
        pending <= ~clear;
      else
        pending <= rise;
    end
  end

endmodule
`endif

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, reset/interrupt vector loads, redirect, stall, IF/ID.
// Interrupt entry is built only when FETCH_INT_EN is defined.
//   state   | meaning
//   VEC_RST | read reset vector from M[RST_VEC_ADDR] into pc
//   RUN     | fetch M[pc] into IF/ID
//   VEC_INT | marker issued, read interrupt vector from M[INT_VEC_ADDR]
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]    RST_VEC_ADDR = cpu_pkg::RST_VEC_ADDR,
  parameter logic [PC_W-1:0]    INT_VEC_ADDR = cpu_pkg::INT_VEC_ADDR,
  parameter logic [INSTR_W-1:0] NOP_INSTR    = cpu_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               int_sig,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_plus1,
  output logic               ifid_valid,
  output logic               ifid_int
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  ifid_t        ifid_q;

  logic load_vec;
  logic do_redirect;
  logic do_fetch;
  logic do_bubble;
  logic do_marker;

`ifdef FETCH_INT_EN
  logic pending;
  logic int_abort;

  int_pending u_int_pending (
    .clk         (clk),
    .rst         (rst),
    .int_sig     (int_sig),
    .clear       (do_marker),
    .reset_abort (int_abort),
    .pending     (pending)
  );
`else
  logic unused_int_sig;
  assign unused_int_sig = int_sig;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= VEC_RST;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      VEC_RST: state_nxt = RUN;
      RUN: begin
`ifdef FETCH_INT_EN
        if (!redirect && !stall && pending) state_nxt = VEC_INT;
`endif
      end
`ifdef FETCH_INT_EN
      VEC_INT: begin
        if (redirect || !stall) state_nxt = RUN;
      end
`endif
      default: state_nxt = VEC_RST;
    endcase
  end

  always_comb begin
    imem_addr   = pc;
    load_vec    = 1'b0;
    do_redirect = 1'b0;
    do_fetch    = 1'b0;
    do_bubble   = 1'b0;
    do_marker   = 1'b0;
`ifdef FETCH_INT_EN
    int_abort   = 1'b0;
`endif
    case (state)
      VEC_RST: begin
        imem_addr = RST_VEC_ADDR;
        load_vec  = 1'b1;
        do_bubble = 1'b1;
      end
      RUN: begin
        if (redirect) begin
          do_redirect = 1'b1;
          do_bubble   = 1'b1;
        end else if (stall) begin
          do_fetch = 1'b0;
`ifdef FETCH_INT_EN
        end else if (pending) begin
          do_marker = 1'b1;
`endif
        end else begin
          do_fetch = 1'b1;
        end
      end
`ifdef FETCH_INT_EN
      // A redirect here means execute flushed the marker; the interrupt retries.
      VEC_INT: begin
        imem_addr = INT_VEC_ADDR;
        if (redirect) begin
          do_redirect = 1'b1;
          do_bubble   = 1'b1;
          int_abort   = 1'b1;
        end else if (!stall) begin
          load_vec = 1'b1;
        end
      end
`endif
      default: imem_addr = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)              pc <= '0;
    else if (load_vec)    pc <= imem_rdata;
    else if (do_redirect) pc <= redirect_pc;
    else if (do_fetch)    pc <= pc_inc(pc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.pc       <= '0;
      ifid_q.pc_plus1 <= PC_W'(1);
      ifid_q.valid    <= 1'b0;
    end else if (do_bubble) begin
      ifid_q.instr <= NOP_INSTR;
      ifid_q.valid <= 1'b0;
    end else if (do_marker) begin
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.pc       <= pc;
      ifid_q.pc_plus1 <= pc_inc(pc);
      ifid_q.valid    <= 1'b0;
    end else if (do_fetch) begin
      ifid_q.instr    <= imem_rdata;
      ifid_q.pc       <= pc;
      ifid_q.pc_plus1 <= pc_inc(pc);
      ifid_q.valid    <= 1'b1;
    end
  end

`ifdef FETCH_INT_EN
  always_ff @(posedge clk) begin
    if (rst)            ifid_int <= 1'b0;
    else if (do_bubble) ifid_int <= 1'b0;
    else if (do_marker) ifid_int <= 1'b1;
    else if (do_fetch)  ifid_int <= 1'b0;
  end
`else
  assign ifid_int = 1'b0;
`endif

  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus1 = ifid_q.pc_plus1;
  assign ifid_valid    = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations plus a randomized run, all compared against a behavioural model.
module tb_fetch_stage;

  localparam logic [7:0] RST_A = 8'h00;
  localparam logic [7:0] INT_A = 8'h01;
  localparam logic [7:0] NOP   = 8'h00;
`ifdef FETCH_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       int_sig = 1'b0;
  logic [7:0] imem_addr, imem_rdata, pc, ifid_instr, ifid_pc, ifid_pc_plus1;
  logic       ifid_valid, ifid_int;
  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr];

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .int_sig(int_sig), .pc(pc), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid), .ifid_int(ifid_int)
  );

  // Behavioural model: "boot" = reading reset vector, "vint" = reading ISR vector.
  bit       m_boot, m_vint, m_pend, m_prev, m_valid, m_int;
  bit [7:0] m_pc, m_instr, m_ipc;

  function automatic bit [7:0] m_addr();
    if (m_boot) return RST_A;
    if (m_vint) return INT_A;
    return m_pc;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_vint = 0; m_pend = 0; m_prev = 0;
    m_pc = 8'h00; m_instr = NOP; m_ipc = 8'h00; m_valid = 0; m_int = 0;
  endtask

  task automatic model_step();
    bit       rise, take, abort, bubble;
    bit [7:0] rd;
    rise = INT_EN && int_sig && !m_prev;
    rd = mem[m_addr()];
    take = 0; abort = 0; bubble = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_boot) begin
      m_pc = rd; m_boot = 0; bubble = 1;
    end else if (m_vint) begin
      if (redirect) begin
        m_pc = redirect_pc; m_vint = 0; abort = 1; bubble = 1;
      end else if (!stall) begin
        m_pc = rd; m_vint = 0;
      end
    end else if (redirect) begin
      m_pc = redirect_pc; bubble = 1;
    end else if (stall) begin
      // everything holds
    end else if (m_pend) begin
      m_valid = 0; m_int = 1; m_ipc = m_pc; m_instr = NOP; m_vint = 1; take = 1;
    end else begin
      m_instr = rd; m_ipc = m_pc; m_valid = 1; m_int = 0; m_pc = m_pc + 8'd1;
    end
    if (bubble) begin
      m_valid = 0; m_int = 0; m_instr = NOP;
    end
    if (abort)     m_pend = 1;
    else if (take) m_pend = 0;
    else           m_pend = m_pend | rise;
    m_prev = INT_EN ? int_sig : 1'b0;
  endtask

  task automatic compare();
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_addr());
    chk("ifid_valid", ifid_valid, m_valid);
    chk("ifid_int", ifid_int, m_int);
    if (m_valid || m_int) begin
      chk("ifid_pc", ifid_pc, m_ipc);
      chk("ifid_pc_plus1", ifid_pc_plus1, 8'(m_ipc + 8'd1));
    end
    if (m_valid) chk("ifid_instr", ifid_instr, m_instr);
    if (!m_valid && !m_int) chk("bubble_instr", ifid_instr, NOP);
  endtask

  // One clock: model advances with the inputs held over the edge, then compare.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[8'h00] = 8'h10;
    mem[8'h10] = 8'h7C;
    mem[8'h01] = 8'h40;
    model_reset();

    rst = 1; cycle(); cycle();
    chk("rst_pc", pc, 8'h00);
    chk("rst_plus1", ifid_pc_plus1, 8'h01);
    chk("rst_addr", imem_addr, 8'h00);

    rst = 0; cycle();
    chk("e1_pc", pc, 8'h10);
    cycle();
    chk("e2_instr", ifid_instr, 8'h7C);
    chk("e2_pc", ifid_pc, 8'h10);
    chk("e2_valid", ifid_valid, 1);

    cycle();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pc", pc, 8'h12);
      chk("stall_ifid_pc", ifid_pc, 8'h11);
    end
    stall = 0; int_sig = 1; cycle();
    chk("resume_ifid_pc", ifid_pc, 8'h12);
    chk("resume_valid", ifid_valid, 1);
`ifdef FETCH_INT_EN
    cycle();
    chk("marker_int", ifid_int, 1);
    chk("marker_pc", ifid_pc, 8'h13);
    chk("marker_hold_pc", pc, 8'h13);
    cycle();
    chk("isr_pc", pc, 8'h40);
    cycle();
    chk("isr_ifid_pc", ifid_pc, 8'h40);
    chk("isr_valid", ifid_valid, 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("held_no_reentry", ifid_int, 0);
    end

    int_sig = 0; cycle();
    int_sig = 1; cycle();
    cycle();
    chk("abort_marker", ifid_int, 1);
    redirect = 1; redirect_pc = 8'h30; cycle();
    chk("abort_pc", pc, 8'h30);
    chk("abort_bubble", ifid_valid, 0);
    redirect = 0; cycle();
    chk("reentry_int", ifid_int, 1);
    chk("reentry_pc", ifid_pc, 8'h30);
    cycle();
    chk("reentry_vec", pc, 8'h40);
`else
    for (int i = 0; i < 4; i++) cycle();
`endif
    int_sig = 0;
    for (int i = 0; i < 3; i++) cycle();

    redirect = 1; redirect_pc = 8'h15; cycle();
    redirect = 0; cycle();
    chk("pre_redir_pc", ifid_pc, 8'h15);
    redirect = 1; redirect_pc = 8'h23; cycle();
    chk("redir_bubble", ifid_valid, 0);
    chk("redir_target", pc, 8'h23);
    redirect = 0; cycle();
    chk("redir_ifid_pc", ifid_pc, 8'h23);
    chk("redir_valid", ifid_valid, 1);

    redirect = 1; redirect_pc = 8'hFF; cycle();
    redirect = 0; cycle();
    chk("wrap_ff", ifid_pc, 8'hFF);
    chk("wrap_pc", pc, 8'h00);
    chk("wrap_plus1", ifid_pc_plus1, 8'h00);
    cycle();
    chk("wrap_00", ifid_pc, 8'h00);

    stall = 1; cycle();
    rst = 1; redirect = 1; redirect_pc = 8'h55; cycle();
    chk("midrst_pc", pc, 8'h00);
    chk("midrst_valid", ifid_valid, 0);
    chk("midrst_instr", ifid_instr, NOP);
    chk("midrst_plus1", ifid_pc_plus1, 8'h01);
    chk("midrst_addr", imem_addr, RST_A);
    rst = 0; stall = 0; redirect = 0;

    for (int i = 0; i < 3000; i++) begin
      stall       = ($urandom_range(0, 99) < 20);
      redirect    = ($urandom_range(0, 99) < 10);
      redirect_pc = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 15) int_sig = ~int_sig;
      rst         = ($urandom_range(0, 999) < 8);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
